// File: rtl/dbus_pkg.sv
// Shared types and helpers for the core-to-SoC data-bus bridge.
// Optional request timeout is enabled with DBUS_TIMEOUT_EN.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } dbus_state_e;

    localparam logic [2:0] DLEN_B = 3'b001;
    localparam logic [2:0] DLEN_H = 3'b010;
    localparam logic [2:0] DLEN_W = 3'b100;

    function automatic logic [3:0] dbus_be(
        input logic [2:0] size,
        input logic [1:0] addr
    );
        case (size)
            DLEN_B:  return 4'b0001 << addr;
            DLEN_H:  return 4'b0011 << {addr[1], 1'b0};
            DLEN_W:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Also flags a size code that is not one-hot: such accesses never reach the bus.
    function automatic logic dbus_misaligned(
        input logic [2:0] size,
        input logic [1:0] addr
    );
        case (size)
            DLEN_B:  return 1'b0;
            DLEN_H:  return addr[0];
            DLEN_W:  return addr != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Byte-lane steering between the core's right-aligned data
// and the SoC bus word lanes.
module dbus_lane_align
    import dbus_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [31:0] wdata_in,
    output logic [31:0] wdata_out,
    input  logic [1:0]  roff,
    input  logic [31:0] rdata_in,
    output logic [31:0] rdata_out
);

    always_comb begin
        case (size)
            DLEN_B:  wdata_out = {4{wdata_in[7:0]}};
            DLEN_H:  wdata_out = {2{wdata_in[15:0]}};
            default: wdata_out = wdata_in;
        endcase
        rdata_out = rdata_in >> {roff, 3'b000};
    end

endmodule

// File: rtl/dbus_bridge.sv
// Data-bus bridge: one core request becomes one req/ack bus beat.
// Define DBUS_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES cycles.
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        DAS,
    input  logic        DRD,
    input  logic        DWR,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    input  logic [2:0]  DLEN,
    output logic [31:0] DATAI,
    output logic        HLT,
    output logic        BERR,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    dbus_state_e state_q, state_d;
    logic [31:0] datai_q, datai_d;
    logic        berr_q, berr_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  off_q, off_d;
`ifdef DBUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    logic        new_acc;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_sh;

    dbus_lane_align u_align (
        .size      (DLEN),
        .wdata_in  (DATAO),
        .wdata_out (wdata_rep),
        .roff      (off_q),
        .rdata_in  (bus_rdata),
        .rdata_out (rdata_sh)
    );

    assign new_acc = DAS & (DRD | DWR);

    always_comb begin
        state_d     = state_q;
        datai_d     = datai_q;
        berr_d      = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        off_d       = off_q;
`ifdef DBUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (new_acc) begin
                    bus_addr_d  = {DADDR[31:2], 2'b00};
                    off_d       = DADDR[1:0];
                    bus_we_d    = DWR;
                    bus_be_d    = dbus_be(DLEN, DADDR[1:0]);
                    bus_wdata_d = wdata_rep;
                    if (dbus_misaligned(DLEN, DADDR[1:0])) begin
                        state_d = RESP;
                        berr_d  = 1'b1;
                    end else begin
                        state_d   = REQ;
                        bus_req_d = 1'b1;
`ifdef DBUS_TIMEOUT_EN
                        cnt_d     = 16'd0;
`endif
                    end
                end
            end
            REQ: begin
                if (bus_err) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    berr_d    = 1'b1;
                end else if (bus_ack) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    datai_d   = rdata_sh;
                end
`ifdef DBUS_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    berr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= IDLE;
            datai_q     <= 32'd0;
            berr_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            off_q       <= 2'd0;
`ifdef DBUS_TIMEOUT_EN
            cnt_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            datai_q     <= datai_d;
            berr_q      <= berr_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            off_q       <= off_d;
`ifdef DBUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Hold the core while a fresh request is seen and throughout REQ.
    assign HLT = ~RES & ((state_q == REQ) | ((state_q == IDLE) & new_acc));

    assign DATAI     = datai_q;
    assign BERR      = berr_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge: fixed vector table, random accesses
// against a reference model, and reset/timeout sequences.
module tb_dbus_bridge;

    localparam int TO = 255;

    logic        CLK = 1'b0;
    logic        RES;
    logic        DAS, DRD, DWR;
    logic [31:0] DADDR, DATAO;
    logic [2:0]  DLEN;
    logic [31:0] DATAI;
    logic        HLT, BERR;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] d;
        logic [2:0]  len;
        int          dly;
        logic        er;
        logic [31:0] rdat;
        int          exp_hlt;
        int          exp_req;
        logic        exp_berr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic        chk_datai;
        logic [31:0] exp_datai;
    } vec_t;

    vec_t tbl[11];

    dbus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK       (CLK),
        .RES       (RES),
        .DAS       (DAS),
        .DRD       (DRD),
        .DWR       (DWR),
        .DADDR     (DADDR),
        .DATAO     (DATAO),
        .DLEN      (DLEN),
        .DATAI     (DATAI),
        .HLT       (HLT),
        .BERR      (BERR),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t tv(
        input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] d,
        input logic [2:0] len, input int dly, input logic er, input logic [31:0] rdat,
        input int hlt, input int req, input logic berr, input logic [3:0] be,
        input logic [31:0] wdata, input logic [31:0] eaddr, input logic we,
        input logic chkd, input logic [31:0] datai
    );
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.d = d; v.len = len;
        v.dly = dly; v.er = er; v.rdat = rdat;
        v.exp_hlt = hlt; v.exp_req = req; v.exp_berr = berr;
        v.exp_be = be; v.exp_wdata = wdata; v.exp_addr = eaddr;
        v.exp_we = we; v.chk_datai = chkd; v.exp_datai = datai;
        return v;
    endfunction

    // Reference model: derives the expected outcome from access size in bytes.
    function automatic vec_t model(
        input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
        input logic [2:0] len, input int dly, input logic er, input logic [31:0] rdat
    );
        vec_t v;
        int   n;
        logic ok;
        logic [31:0] sh;
        v = tv(rd, wr, a, d, len, dly, er, rdat, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : (len == 3'd4) ? 4 : 0;
        ok = (n != 0) && ((a % n) == 0);
        v.exp_hlt = ok ? 1 + dly : 1;
        v.exp_req = ok ? dly : 0;
        v.exp_berr = !ok || er;
        if (ok) begin
            v.exp_be = 4'(((1 << n) - 1) << (a % 4));
            for (int i = 0; i < 4; i++) begin
                sh = d >> (8 * (i % n));
                v.exp_wdata[8*i +: 8] = sh[7:0];
            end
            v.exp_addr = a - (a % 4);
            v.exp_we = wr;
        end
        v.chk_datai = ok && !er && rd && !wr;
        v.exp_datai = rdat >> (8 * (a % 4));
        return v;
    endfunction

    // Starts right after a posedge with the DUT idle; ends likewise.
    task automatic apply(input vec_t v, input string tag);
        int hlt_n = 0, req_n = 0, rises = 0;
        logic prev = 1'b0, unstable = 1'b0, done = 1'b0;
        logic berr_s = 1'b0;
        logic [31:0] datai_s = '0, a_s = '0, w_s = '0;
        logic [3:0] be_s = '0;
        logic we_s = 1'b0;
        DAS = 1'b1; DRD = v.rd; DWR = v.wr;
        DADDR = v.addr; DATAO = v.d; DLEN = v.len;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (bus_req && !prev) rises++;
            prev = bus_req;
            if (!HLT) begin
                berr_s = BERR;
                datai_s = DATAI;
                done = 1'b1;
                break;
            end
            hlt_n++;
            if (bus_req) begin
                req_n++;
                if (req_n == 1) begin
                    a_s = bus_addr; w_s = bus_wdata; be_s = bus_be; we_s = bus_we;
                end else if (a_s !== bus_addr || w_s !== bus_wdata ||
                             be_s !== bus_be || we_s !== bus_we) begin
                    unstable = 1'b1;
                end
                bus_ack = (req_n == v.dly);
                bus_err = (req_n == v.dly) && v.er;
                bus_rdata = v.rdat;
            end else begin
                bus_ack = 1'($urandom);
                bus_err = 1'($urandom);
                bus_rdata = $urandom;
            end
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " hlt"}, hlt_n, v.exp_hlt);
        chk({tag, " req"}, req_n, v.exp_req);
        chk({tag, " rises"}, rises, (v.exp_req > 0) ? 1 : 0);
        chk({tag, " berr"}, 32'(berr_s), 32'(v.exp_berr));
        if (v.exp_req > 0) begin
            chk({tag, " be"}, 32'(be_s), 32'(v.exp_be));
            chk({tag, " addr"}, a_s, v.exp_addr);
            chk({tag, " wdata"}, w_s, v.exp_wdata);
            chk({tag, " we"}, 32'(we_s), 32'(v.exp_we));
            chk({tag, " stable"}, 32'(unstable), 32'd0);
        end
        if (v.chk_datai) chk({tag, " datai"}, DATAI, v.exp_datai);
        @(posedge CLK); #1;
        DAS = 1'b0; DRD = 1'b0; DWR = 1'b0;
        @(negedge CLK);
        chk({tag, " idle berr"}, 32'(BERR), 32'd0);
        chk({tag, " idle req"}, 32'(bus_req), 32'd0);
        chk({tag, " idle hlt"}, 32'(HLT), 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        int   n;
        logic got, b;
        logic [2:0] len;
        int   k;
        vec_t v;

        tbl[0]  = tv(1, 0, 32'h1000, 32'h0, 3'b100, 2, 0, 32'hDEADBEEF,
                     3, 2, 0, 4'hF, 32'h0, 32'h1000, 0, 1, 32'hDEADBEEF);
        tbl[1]  = tv(0, 1, 32'h2003, 32'h123456A5, 3'b001, 1, 0, 32'h0,
                     2, 1, 0, 4'b1000, 32'hA5A5A5A5, 32'h2000, 1, 0, 32'h0);
        tbl[2]  = tv(1, 0, 32'h3002, 32'h0, 3'b010, 1, 0, 32'h1234ABCD,
                     2, 1, 0, 4'b1100, 32'h0, 32'h3000, 0, 1, 32'h00001234);
        tbl[3]  = tv(0, 1, 32'h4001, 32'h11223344, 3'b100, 1, 0, 32'h0,
                     1, 0, 1, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        tbl[4]  = tv(1, 0, 32'h5000, 32'h0, 3'b100, 1, 1, 32'hFFFFFFFF,
                     2, 1, 1, 4'hF, 32'h0, 32'h5000, 0, 0, 32'h0);
        tbl[5]  = tv(1, 1, 32'h6006, 32'h0000BEEF, 3'b010, 3, 0, 32'h0,
                     4, 3, 0, 4'b1100, 32'hBEEFBEEF, 32'h6004, 1, 0, 32'h0);
        tbl[6]  = tv(1, 0, 32'h7001, 32'h0, 3'b001, 1, 0, 32'hDEADBEEF,
                     2, 1, 0, 4'b0010, 32'h0, 32'h7000, 0, 1, 32'h00DEADBE);
        tbl[7]  = tv(1, 0, 32'h8000, 32'h0, 3'b011, 1, 0, 32'h0,
                     1, 0, 1, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        tbl[8]  = tv(1, 0, 32'h9000, 32'h0, 3'b000, 1, 0, 32'h0,
                     1, 0, 1, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        tbl[9]  = tv(0, 1, 32'hA001, 32'h5555, 3'b010, 1, 0, 32'h0,
                     1, 0, 1, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        tbl[10] = tv(0, 1, 32'hB000, 32'h89ABCDEF, 3'b100, 4, 0, 32'h0,
                     5, 4, 0, 4'hF, 32'h89ABCDEF, 32'hB000, 1, 0, 32'h0);

        RES = 1'b1; DAS = 0; DRD = 0; DWR = 0;
        DADDR = '0; DATAO = '0; DLEN = '0;
        bus_ack = 0; bus_err = 0; bus_rdata = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst datai", DATAI, 32'h0);
        chk("rst hlt", 32'(HLT), 32'd0);
        chk("rst berr", 32'(BERR), 32'd0);
        chk("rst req", 32'(bus_req), 32'd0);
        chk("rst we", 32'(bus_we), 32'd0);
        chk("rst addr", bus_addr, 32'h0);
        chk("rst be", 32'(bus_be), 32'h0);
        chk("rst wdata", bus_wdata, 32'h0);
        @(posedge CLK); #1;
        RES = 1'b0;

        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Strobe without read or write must not start anything.
        DAS = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("das_only hlt", 32'(HLT), 32'd0);
            chk("das_only req", 32'(bus_req), 32'd0);
        end
        @(posedge CLK); #1;
        DAS = 1'b0;

        // Reset during the second REQ cycle.
        bus_ack = 0; bus_err = 0;
        DAS = 1; DRD = 1; DWR = 0; DADDR = 32'hC000; DLEN = 3'b100;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst6 req1", 32'(bus_req), 32'd1);
        @(negedge CLK);
        RES = 1; DAS = 0; DRD = 0;
        @(negedge CLK);
        chk("rst6 req", 32'(bus_req), 32'd0);
        chk("rst6 hlt", 32'(HLT), 32'd0);
        chk("rst6 berr", 32'(BERR), 32'd0);
        @(posedge CLK); #1;
        RES = 0;
        @(negedge CLK);
        chk("rst6 berr2", 32'(BERR), 32'd0);
        chk("rst6 req2", 32'(bus_req), 32'd0);
        @(posedge CLK); #1;
        apply(tbl[0], "after_rst");

        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(7));
            len = (k < 3) ? 3'b001 : (k < 5) ? 3'b010 : (k < 7) ? 3'b100 : 3'($urandom);
            k = int'($urandom_range(2));
            v = model(k != 1, k != 0, $urandom, $urandom, len,
                      int'($urandom_range(4, 1)), ($urandom_range(7) == 0), $urandom);
            apply(v, $sformatf("rnd%0d", i));
        end

        // A request the bus never answers.
        bus_ack = 0; bus_err = 0;
        DAS = 1; DRD = 1; DWR = 0; DADDR = 32'hD000; DLEN = 3'b100;
        n = 0; got = 0; b = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (bus_req) n++;
            if (!HLT) begin
                got = 1; b = BERR;
                break;
            end
        end
`ifdef DBUS_TIMEOUT_EN
        chk("to req", n, TO);
        chk("to resp", 32'(got), 32'd1);
        chk("to berr", 32'(b), 32'd1);
`else
        chk("nto req", n, 399);
        chk("nto hold", 32'(got), 32'd0);
`endif
        @(posedge CLK); #1;
        DAS = 0; DRD = 0; RES = 1;
        @(posedge CLK); #1;
        RES = 0;
        @(negedge CLK);
        chk("nto req_off", 32'(bus_req), 32'd0);
        @(posedge CLK); #1;
        apply(tbl[2], "after_to");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
